// File: rtl/wb_pkg.sv
// Shared definitions for the MEM->WB lane bundle: lane geometry, field
// offsets inside a packed lane, and the beat count helper.
package wb_pkg;

    // Default field widths of one lane
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_PC_W   = 32;

    // Width of one packed lane: {we, dest, result, pc}
    function automatic int lane_w(input int addr_w, input int data_w, input int pc_w);
        return 1 + addr_w + data_w + pc_w;
    endfunction

    // Number of write beats needed to retire LANES results over WPORTS ports
    function automatic int nbeats(input int lanes, input int wports);
        return (lanes + wports - 1) / wports;
    endfunction

    // Field offsets (LSB position) inside a lane, for arbitrary widths
    function automatic int res_off(input int pc_w);
        return pc_w;
    endfunction

    function automatic int dest_off(input int data_w, input int pc_w);
        return pc_w + data_w;
    endfunction

    function automatic int we_off(input int addr_w, input int data_w, input int pc_w);
        return pc_w + data_w + addr_w;
    endfunction

    // Field offsets at the default widths
    localparam int PC_OFF   = 0;
    localparam int RES_OFF  = res_off(DEF_PC_W);
    localparam int DEST_OFF = dest_off(DEF_DATA_W, DEF_PC_W);
    localparam int WE_OFF   = we_off(DEF_ADDR_W, DEF_DATA_W, DEF_PC_W);

    // One lane as seen by MEM and WB at the default widths (MSB first)
    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] dest;
        logic [DEF_DATA_W-1:0] result;
        logic [DEF_PC_W-1:0]   pc;
    } wb_lane_t;

endpackage

// File: rtl/wb_beat_sel.sv
// Combinational lane selector: for the current beat, routes lanes
// beat*WPORTS+p onto write port p and masks ports whose lane does not
// exist, writes r0, or is overwritten by a younger lane in the same beat.
import wb_pkg::*;

module wb_beat_sel #(
    parameter int LANES  = 2,
    parameter int WPORTS = 1,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int BEAT_W = 1
) (
    input  logic                                          valid,
    input  logic [BEAT_W-1:0]                             beat,
    input  logic [LANES*lane_w(ADDR_W, DATA_W, PC_W)-1:0] bundle,
    output logic [WPORTS-1:0]                             rf_we,
    output logic [WPORTS*ADDR_W-1:0]                      rf_waddr,
    output logic [WPORTS*DATA_W-1:0]                      rf_wdata,
    output logic [WPORTS*PC_W-1:0]                        debug_pc,
    output logic [WPORTS-1:0]                             debug_valid
);

    localparam int LANE_W  = lane_w(ADDR_W, DATA_W, PC_W);
    localparam int WE_O    = we_off(ADDR_W, DATA_W, PC_W);
    localparam int DEST_O  = dest_off(DATA_W, PC_W);
    localparam int RES_O   = res_off(PC_W);

    logic [LANE_W-1:0] lane_bits;
    logic              p_exist [WPORTS];
    logic              p_we    [WPORTS];
    logic [ADDR_W-1:0] p_dest  [WPORTS];
    logic [DATA_W-1:0] p_res   [WPORTS];
    logic [PC_W-1:0]   p_pc    [WPORTS];
    int                lane_idx;

    // Pick the lane for each port; a port past the last lane reads as zero
    always_comb begin
        lane_bits = '0;
        lane_idx  = 0;
        for (int p = 0; p < WPORTS; p++) begin
            p_exist[p] = 1'b0;
            p_we[p]    = 1'b0;
            p_dest[p]  = '0;
            p_res[p]   = '0;
            p_pc[p]    = '0;
            lane_idx   = int'(beat) * WPORTS + p;
            if (lane_idx < LANES) begin
                lane_bits  = bundle[lane_idx*LANE_W +: LANE_W];
                p_exist[p] = 1'b1;
                p_we[p]    = lane_bits[WE_O];
                p_dest[p]  = lane_bits[DEST_O +: ADDR_W];
                p_res[p]   = lane_bits[RES_O +: DATA_W];
                p_pc[p]    = lane_bits[PC_OFF +: PC_W];
            end
        end
    end

    // Drive the ports; a higher port with the same dest is younger in
    // program order, so it shadows every lower port that targets that dest
    always_comb begin
        rf_we       = '0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        debug_pc    = '0;
        debug_valid = '0;
        for (int p = 0; p < WPORTS; p++) begin
            logic shadowed;
            shadowed = 1'b0;
            for (int q = p + 1; q < WPORTS; q++) begin
                if (p_exist[q] && p_we[q] && (p_dest[q] == p_dest[p]))
                    shadowed = 1'b1;
            end
            rf_we[p]                       = valid & p_exist[p] & p_we[p] &
                                             (p_dest[p] != '0) & ~shadowed;
            debug_valid[p]                 = valid & p_exist[p];
            rf_waddr[p*ADDR_W +: ADDR_W]   = p_dest[p];
            rf_wdata[p*DATA_W +: DATA_W]   = p_res[p];
            debug_pc[p*PC_W +: PC_W]       = p_pc[p];
        end
    end

endmodule

// File: rtl/stage_5_wb_multi.sv
// Writeback stage: holds one LANES-wide bundle from MEM and retires it over
// WPORTS register-file write ports, one beat per cycle. Exposes pending
// destinations for hazard checks, difftest debug ports and a retire counter.
//
// Handshake: MEM presents valid_4 with stage_4_to_5; the bundle transfers on
// a rising edge where valid_4 && allow_5 && !flush. allow_5 is a function of
// WB state only (never of valid_4) and is high when WB is empty or is on the
// final beat of its current bundle. flush kills the held bundle at the edge
// and drops whatever MEM offers in that cycle.
import wb_pkg::*;

module stage_5_wb_multi #(
    parameter int LANES  = 2,
    parameter int WPORTS = 1,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int PC_W   = 32,
    parameter int CNT_W  = 32
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          valid_4,
    output logic                                          allow_5,
    input  logic [LANES*lane_w(ADDR_W, DATA_W, PC_W)-1:0] stage_4_to_5,
    input  logic                                          flush,
    output logic [WPORTS-1:0]                             rf_we,
    output logic [WPORTS*ADDR_W-1:0]                      rf_waddr,
    output logic [WPORTS*DATA_W-1:0]                      rf_wdata,
    output logic [WPORTS*PC_W-1:0]                        debug_wb_pc,
    output logic [WPORTS-1:0]                             debug_wb_valid,
    output logic [LANES-1:0]                              wb_pend_valid,
    output logic [LANES*ADDR_W-1:0]                       wb_pend_dest,
    output logic [CNT_W-1:0]                              perf_retired
);

    localparam int LANE_W = lane_w(ADDR_W, DATA_W, PC_W);
    localparam int NBEATS = nbeats(LANES, WPORTS);
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int WE_O   = we_off(ADDR_W, DATA_W, PC_W);
    localparam int DEST_O = dest_off(DATA_W, PC_W);

    logic                    valid_5;
    logic [BEAT_W-1:0]       beat;
    logic [LANES*LANE_W-1:0] bundle_q;
    logic                    ready_go_5;
    logic                    accept;
    logic [CNT_W-1:0]        retire_inc;

    assign ready_go_5 = (beat == BEAT_W'(NBEATS - 1));
    assign allow_5    = ~valid_5 | ready_go_5;
    assign accept     = valid_4 & allow_5 & ~flush;

    // Bundle holding register and beat sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_5  <= 1'b0;
            beat     <= '0;
            bundle_q <= '0;
        end else if (flush) begin
            valid_5 <= 1'b0;
            beat    <= '0;
        end else if (accept) begin
            bundle_q <= stage_4_to_5;
            valid_5  <= 1'b1;
            beat     <= '0;
        end else if (valid_5 && !ready_go_5) begin
            beat <= beat + 1'b1;
        end else if (valid_5) begin
            valid_5 <= 1'b0;
            beat    <= '0;
        end
    end

    wb_beat_sel #(
        .LANES  (LANES),
        .WPORTS (WPORTS),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .BEAT_W (BEAT_W)
    ) u_beat_sel (
        .valid       (valid_5),
        .beat        (beat),
        .bundle      (bundle_q),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .debug_pc    (debug_wb_pc),
        .debug_valid (debug_wb_valid)
    );

    // Lanes from the current beat onward still count as pending, since the
    // register file only takes the current beat's write at the next edge
    always_comb begin
        wb_pend_valid = '0;
        wb_pend_dest  = '0;
        for (int i = 0; i < LANES; i++) begin
            wb_pend_dest[i*ADDR_W +: ADDR_W] = bundle_q[i*LANE_W + DEST_O +: ADDR_W];
            wb_pend_valid[i] = valid_5 & bundle_q[i*LANE_W + WE_O] &
                               (bundle_q[i*LANE_W + DEST_O +: ADDR_W] != '0) &
                               (i >= int'(beat) * WPORTS);
        end
    end

    // Number of lanes retiring this cycle
    always_comb begin
        retire_inc = '0;
        for (int p = 0; p < WPORTS; p++)
            retire_inc = retire_inc + CNT_W'(debug_wb_valid[p]);
    end

    // Retire counter, wraps naturally
    always_ff @(posedge clk) begin
        if (reset)
            perf_retired <= '0;
        else
            perf_retired <= perf_retired + retire_inc;
    end

endmodule

// File: tb/tb_stage_5_wb_multi.sv
// Directed bench for stage_5_wb_multi using three configurations:
// dut_a LANES=2/WPORTS=1, dut_b LANES=2/WPORTS=2, dut_c LANES=3/WPORTS=2.
module tb_stage_5_wb_multi;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // dut_a: LANES=2 WPORTS=1
    logic         a_reset, a_valid_4, a_allow_5, a_flush;
    logic [139:0] a_bundle;
    logic [0:0]   a_rf_we, a_dv;
    logic [4:0]   a_waddr;
    logic [31:0]  a_wdata, a_pc, a_perf;
    logic [1:0]   a_pend;
    logic [9:0]   a_pend_dest;

    // dut_b: LANES=2 WPORTS=2
    logic         b_reset, b_valid_4, b_allow_5, b_flush;
    logic [139:0] b_bundle;
    logic [1:0]   b_rf_we, b_dv, b_pend;
    logic [9:0]   b_waddr, b_pend_dest;
    logic [63:0]  b_wdata, b_pc;
    logic [31:0]  b_perf;

    // dut_c: LANES=3 WPORTS=2
    logic         c_reset, c_valid_4, c_allow_5, c_flush;
    logic [209:0] c_bundle;
    logic [1:0]   c_rf_we, c_dv;
    logic [2:0]   c_pend;
    logic [9:0]   c_waddr;
    logic [14:0]  c_pend_dest;
    logic [63:0]  c_wdata, c_pc;
    logic [31:0]  c_perf;

    // scoreboard of expected register-file writes {addr, data}
    logic [36:0] exp_q[$];

    stage_5_wb_multi #(.LANES(2), .WPORTS(1)) dut_a (
        .clk(clk), .reset(a_reset), .valid_4(a_valid_4), .allow_5(a_allow_5),
        .stage_4_to_5(a_bundle), .flush(a_flush), .rf_we(a_rf_we),
        .rf_waddr(a_waddr), .rf_wdata(a_wdata), .debug_wb_pc(a_pc),
        .debug_wb_valid(a_dv), .wb_pend_valid(a_pend), .wb_pend_dest(a_pend_dest),
        .perf_retired(a_perf)
    );

    stage_5_wb_multi #(.LANES(2), .WPORTS(2)) dut_b (
        .clk(clk), .reset(b_reset), .valid_4(b_valid_4), .allow_5(b_allow_5),
        .stage_4_to_5(b_bundle), .flush(b_flush), .rf_we(b_rf_we),
        .rf_waddr(b_waddr), .rf_wdata(b_wdata), .debug_wb_pc(b_pc),
        .debug_wb_valid(b_dv), .wb_pend_valid(b_pend), .wb_pend_dest(b_pend_dest),
        .perf_retired(b_perf)
    );

    stage_5_wb_multi #(.LANES(3), .WPORTS(2)) dut_c (
        .clk(clk), .reset(c_reset), .valid_4(c_valid_4), .allow_5(c_allow_5),
        .stage_4_to_5(c_bundle), .flush(c_flush), .rf_we(c_rf_we),
        .rf_waddr(c_waddr), .rf_wdata(c_wdata), .debug_wb_pc(c_pc),
        .debug_wb_valid(c_dv), .wb_pend_valid(c_pend), .wb_pend_dest(c_pend_dest),
        .perf_retired(c_perf)
    );

    // ---------------- driver helpers ----------------
    function automatic logic [69:0] mk(input logic we, input logic [4:0] d,
                                       input logic [31:0] r, input logic [31:0] pc);
        return {we, d, r, pc};
    endfunction

    // advance one clock; outputs are sampled 2 time units after the edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        a_reset = 1; b_reset = 1; c_reset = 1;
        a_valid_4 = 0; b_valid_4 = 0; c_valid_4 = 0;
        a_flush = 0; b_flush = 0; c_flush = 0;
        a_bundle = '0; b_bundle = '0; c_bundle = '0;
        step(); step();
        n_cmp++; if (a_rf_we !== 1'b0) begin n_fail++; $display("FAIL rst_a_we got=%b want=0", a_rf_we); end
        n_cmp++; if (a_dv !== 1'b0) begin n_fail++; $display("FAIL rst_a_dv got=%b want=0", a_dv); end
        n_cmp++; if (a_pend !== 2'b00) begin n_fail++; $display("FAIL rst_a_pend got=%b want=00", a_pend); end
        n_cmp++; if (a_perf !== 32'd0) begin n_fail++; $display("FAIL rst_a_perf got=%0d want=0", a_perf); end
        n_cmp++; if (a_allow_5 !== 1'b1) begin n_fail++; $display("FAIL rst_a_allow got=%b want=1", a_allow_5); end
        n_cmp++; if (b_rf_we !== 2'b00) begin n_fail++; $display("FAIL rst_b_we got=%b want=00", b_rf_we); end
        n_cmp++; if (b_dv !== 2'b00) begin n_fail++; $display("FAIL rst_b_dv got=%b want=00", b_dv); end
        n_cmp++; if (c_pend !== 3'b000) begin n_fail++; $display("FAIL rst_c_pend got=%b want=000", c_pend); end
        n_cmp++; if (c_perf !== 32'd0) begin n_fail++; $display("FAIL rst_c_perf got=%0d want=0", c_perf); end
        a_reset = 0; b_reset = 0; c_reset = 0;
        step();
    endtask

    task automatic test_serialise();
        a_bundle  = {mk(1, 5'd4, 32'h22, 32'h1c000004), mk(1, 5'd3, 32'h11, 32'h1c000000)};
        a_valid_4 = 1;
        step();
        a_valid_4 = 0;
        n_cmp++; if (a_rf_we !== 1'b1) begin n_fail++; $display("FAIL ser_b0_we got=%b want=1", a_rf_we); end
        n_cmp++; if (a_waddr !== 5'd3) begin n_fail++; $display("FAIL ser_b0_waddr got=%0d want=3", a_waddr); end
        n_cmp++; if (a_wdata !== 32'h11) begin n_fail++; $display("FAIL ser_b0_wdata got=%h want=11", a_wdata); end
        n_cmp++; if (a_pc !== 32'h1c000000) begin n_fail++; $display("FAIL ser_b0_pc got=%h want=1c000000", a_pc); end
        n_cmp++; if (a_allow_5 !== 1'b0) begin n_fail++; $display("FAIL ser_b0_allow got=%b want=0", a_allow_5); end
        n_cmp++; if (a_pend !== 2'b11) begin n_fail++; $display("FAIL ser_b0_pend got=%b want=11", a_pend); end
        n_cmp++; if (a_pend_dest !== {5'd4, 5'd3}) begin n_fail++; $display("FAIL ser_pend_dest got=%h want=083", a_pend_dest); end
        step();
        n_cmp++; if (a_rf_we !== 1'b1) begin n_fail++; $display("FAIL ser_b1_we got=%b want=1", a_rf_we); end
        n_cmp++; if (a_waddr !== 5'd4) begin n_fail++; $display("FAIL ser_b1_waddr got=%0d want=4", a_waddr); end
        n_cmp++; if (a_wdata !== 32'h22) begin n_fail++; $display("FAIL ser_b1_wdata got=%h want=22", a_wdata); end
        n_cmp++; if (a_allow_5 !== 1'b1) begin n_fail++; $display("FAIL ser_b1_allow got=%b want=1", a_allow_5); end
        n_cmp++; if (a_pend !== 2'b10) begin n_fail++; $display("FAIL ser_b1_pend got=%b want=10", a_pend); end
        step();
        n_cmp++; if (a_perf !== 32'd2) begin n_fail++; $display("FAIL ser_perf got=%0d want=2", a_perf); end
        n_cmp++; if (a_rf_we !== 1'b0) begin n_fail++; $display("FAIL ser_idle_we got=%b want=0", a_rf_we); end
    endtask

    task automatic test_dest_zero();
        a_bundle  = {mk(0, 5'd7, 32'h44, 32'h1c00000c), mk(1, 5'd0, 32'h33, 32'h1c000008)};
        a_valid_4 = 1;
        step();
        a_valid_4 = 0;
        n_cmp++; if (a_rf_we !== 1'b0) begin n_fail++; $display("FAIL dz_b0_we got=%b want=0", a_rf_we); end
        n_cmp++; if (a_dv !== 1'b1) begin n_fail++; $display("FAIL dz_b0_dv got=%b want=1", a_dv); end
        n_cmp++; if (a_pend !== 2'b00) begin n_fail++; $display("FAIL dz_b0_pend got=%b want=00", a_pend); end
        n_cmp++; if (a_pc !== 32'h1c000008) begin n_fail++; $display("FAIL dz_b0_pc got=%h want=1c000008", a_pc); end
        step();
        n_cmp++; if (a_rf_we !== 1'b0) begin n_fail++; $display("FAIL dz_b1_we got=%b want=0", a_rf_we); end
        n_cmp++; if (a_dv !== 1'b1) begin n_fail++; $display("FAIL dz_b1_dv got=%b want=1", a_dv); end
        n_cmp++; if (a_waddr !== 5'd7) begin n_fail++; $display("FAIL dz_b1_waddr got=%0d want=7", a_waddr); end
        step();
        n_cmp++; if (a_perf !== 32'd4) begin n_fail++; $display("FAIL dz_perf got=%0d want=4", a_perf); end
        n_cmp++; if (a_dv !== 1'b0) begin n_fail++; $display("FAIL dz_idle_dv got=%b want=0", a_dv); end
    endtask

    task automatic test_flush();
        a_bundle  = {mk(1, 5'd7, 32'h77, 32'h1c000014), mk(1, 5'd6, 32'h66, 32'h1c000010)};
        a_valid_4 = 1;
        step();
        // beat 0 on screen: flush now, while MEM offers another bundle
        a_bundle = {mk(1, 5'd9, 32'h99, 32'h1c00001c), mk(1, 5'd8, 32'h88, 32'h1c000018)};
        a_flush  = 1;
        #1;
        n_cmp++; if (a_rf_we !== 1'b1) begin n_fail++; $display("FAIL fl_b0_we got=%b want=1", a_rf_we); end
        n_cmp++; if (a_waddr !== 5'd6) begin n_fail++; $display("FAIL fl_b0_waddr got=%0d want=6", a_waddr); end
        step();
        a_flush = 0; a_valid_4 = 0;
        n_cmp++; if (a_dv !== 1'b0) begin n_fail++; $display("FAIL fl_after_dv got=%b want=0", a_dv); end
        n_cmp++; if (a_rf_we !== 1'b0) begin n_fail++; $display("FAIL fl_after_we got=%b want=0", a_rf_we); end
        n_cmp++; if (a_allow_5 !== 1'b1) begin n_fail++; $display("FAIL fl_after_allow got=%b want=1", a_allow_5); end
        n_cmp++; if (a_perf !== 32'd5) begin n_fail++; $display("FAIL fl_perf got=%0d want=5", a_perf); end
        step();
        n_cmp++; if (a_rf_we !== 1'b0) begin n_fail++; $display("FAIL fl_lane1_we got=%b want=0", a_rf_we); end
        // flush while idle and MEM offers: the offer must be dropped
        a_valid_4 = 1; a_flush = 1;
        #1;
        n_cmp++; if (a_allow_5 !== 1'b1) begin n_fail++; $display("FAIL fl_idle_allow got=%b want=1", a_allow_5); end
        step();
        a_valid_4 = 0; a_flush = 0;
        n_cmp++; if (a_dv !== 1'b0) begin n_fail++; $display("FAIL fl_idle_dv got=%b want=0", a_dv); end
        n_cmp++; if (a_pend !== 2'b00) begin n_fail++; $display("FAIL fl_idle_pend got=%b want=00", a_pend); end
        n_cmp++; if (a_perf !== 32'd5) begin n_fail++; $display("FAIL fl_idle_perf got=%0d want=5", a_perf); end
    endtask

    task automatic test_reset_mid();
        a_bundle  = {mk(1, 5'd13, 32'hd, 32'h1c000024), mk(1, 5'd12, 32'hc, 32'h1c000020)};
        a_valid_4 = 1;
        step();
        a_valid_4 = 0;
        n_cmp++; if (a_rf_we !== 1'b1) begin n_fail++; $display("FAIL rm_b0_we got=%b want=1", a_rf_we); end
        a_reset = 1;
        step();
        n_cmp++; if (a_rf_we !== 1'b0) begin n_fail++; $display("FAIL rm_we got=%b want=0", a_rf_we); end
        n_cmp++; if (a_pend !== 2'b00) begin n_fail++; $display("FAIL rm_pend got=%b want=00", a_pend); end
        n_cmp++; if (a_perf !== 32'd0) begin n_fail++; $display("FAIL rm_perf got=%0d want=0", a_perf); end
        n_cmp++; if (a_allow_5 !== 1'b1) begin n_fail++; $display("FAIL rm_allow got=%b want=1", a_allow_5); end
        a_reset = 0;
        step();
        n_cmp++; if (a_dv !== 1'b0) begin n_fail++; $display("FAIL rm_tail_dv got=%b want=0", a_dv); end
        n_cmp++; if (a_perf !== 32'd0) begin n_fail++; $display("FAIL rm_tail_perf got=%0d want=0", a_perf); end
    endtask

    task automatic test_back_to_back();
        logic [139:0] bund   [4];
        logic [1:0]   exp_we [4];
        logic [1:0]   exp_dv [4];
        bund[0] = {mk(1, 5'd5, 32'hb, 32'h1c000104), mk(1, 5'd5, 32'ha, 32'h1c000100)};
        bund[1] = {mk(1, 5'd9, 32'hd, 32'h1c00010c), mk(1, 5'd8, 32'hc, 32'h1c000108)};
        bund[2] = {mk(0, 5'd11, 32'hf, 32'h1c000114), mk(1, 5'd10, 32'he, 32'h1c000110)};
        bund[3] = '0;
        exp_we[0] = 2'b10; exp_we[1] = 2'b11; exp_we[2] = 2'b01; exp_we[3] = 2'b00;
        exp_dv[0] = 2'b11; exp_dv[1] = 2'b11; exp_dv[2] = 2'b11; exp_dv[3] = 2'b00;
        exp_q.push_back({5'd5, 32'hb});
        exp_q.push_back({5'd8, 32'hc});
        exp_q.push_back({5'd9, 32'hd});
        exp_q.push_back({5'd10, 32'he});
        for (int c = 0; c < 4; c++) begin
            b_bundle  = bund[c];
            b_valid_4 = (c < 3);
            step();
            n_cmp++; if (b_rf_we !== exp_we[c]) begin n_fail++; $display("FAIL b2b_we[%0d] got=%b want=%b", c, b_rf_we, exp_we[c]); end
            n_cmp++; if (b_dv !== exp_dv[c]) begin n_fail++; $display("FAIL b2b_dv[%0d] got=%b want=%b", c, b_dv, exp_dv[c]); end
            n_cmp++; if (b_allow_5 !== 1'b1) begin n_fail++; $display("FAIL b2b_allow[%0d] got=%b want=1", c, b_allow_5); end
            for (int p = 0; p < 2; p++) begin
                if (b_rf_we[p]) begin
                    logic [36:0] exp_w, got_w;
                    got_w = {b_waddr[p*5 +: 5], b_wdata[p*32 +: 32]};
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_fail++; $display("FAIL b2b_extra_write got=%h want=none", got_w);
                    end else begin
                        exp_w = exp_q.pop_front();
                        if (got_w !== exp_w) begin n_fail++; $display("FAIL b2b_write got=%h want=%h", got_w, exp_w); end
                    end
                end
            end
            if (c == 0) begin
                n_cmp++; if (b_pend !== 2'b11) begin n_fail++; $display("FAIL b2b_pend got=%b want=11", b_pend); end
            end
        end
        b_valid_4 = 0;
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing_writes got=%0d want=0", exp_q.size()); end
        n_cmp++; if (b_perf !== 32'd6) begin n_fail++; $display("FAIL b2b_perf got=%0d want=6", b_perf); end
        exp_q.delete();
    endtask

    task automatic test_uneven();
        c_bundle = {mk(1, 5'd3, 32'h303, 32'h1c000208),
                    mk(1, 5'd2, 32'h202, 32'h1c000204),
                    mk(1, 5'd1, 32'h101, 32'h1c000200)};
        c_valid_4 = 1;
        step();
        c_valid_4 = 0;
        n_cmp++; if (c_rf_we !== 2'b11) begin n_fail++; $display("FAIL un_b0_we got=%b want=11", c_rf_we); end
        n_cmp++; if (c_dv !== 2'b11) begin n_fail++; $display("FAIL un_b0_dv got=%b want=11", c_dv); end
        n_cmp++; if (c_pend !== 3'b111) begin n_fail++; $display("FAIL un_b0_pend got=%b want=111", c_pend); end
        n_cmp++; if (c_allow_5 !== 1'b0) begin n_fail++; $display("FAIL un_b0_allow got=%b want=0", c_allow_5); end
        n_cmp++; if (c_waddr !== {5'd2, 5'd1}) begin n_fail++; $display("FAIL un_b0_waddr got=%h want=041", c_waddr); end
        step();
        n_cmp++; if (c_rf_we !== 2'b01) begin n_fail++; $display("FAIL un_b1_we got=%b want=01", c_rf_we); end
        n_cmp++; if (c_dv !== 2'b01) begin n_fail++; $display("FAIL un_b1_dv got=%b want=01", c_dv); end
        n_cmp++; if (c_pend !== 3'b100) begin n_fail++; $display("FAIL un_b1_pend got=%b want=100", c_pend); end
        n_cmp++; if (c_allow_5 !== 1'b1) begin n_fail++; $display("FAIL un_b1_allow got=%b want=1", c_allow_5); end
        n_cmp++; if (c_waddr[4:0] !== 5'd3) begin n_fail++; $display("FAIL un_b1_waddr got=%0d want=3", c_waddr[4:0]); end
        n_cmp++; if (c_wdata[31:0] !== 32'h303) begin n_fail++; $display("FAIL un_b1_wdata got=%h want=303", c_wdata[31:0]); end
        step();
        n_cmp++; if (c_pend !== 3'b000) begin n_fail++; $display("FAIL un_end_pend got=%b want=000", c_pend); end
        n_cmp++; if (c_dv !== 2'b00) begin n_fail++; $display("FAIL un_end_dv got=%b want=00", c_dv); end
        n_cmp++; if (c_perf !== 32'd3) begin n_fail++; $display("FAIL un_perf got=%0d want=3", c_perf); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_serialise();
        test_dest_zero();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_uneven();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/stage_5_wb_multi.md
Name: stage_5_wb_multi

Overview:
- Parametrised writeback stage for the multi-lane pipeline. It sits between the MEM stage and the register file.
- Accepts one bundle of LANES results per handshake from MEM and retires it over WPORTS register-file write ports.
- When LANES > WPORTS, a bundle is serialised over several beats and the stage applies back-pressure to MEM.
- Also provides hazard/bypass visibility of pending destinations, difftest debug outputs, a flush path and a retire counter.

Parameters:
- LANES, 2, results per bundle from MEM (>=1)
- WPORTS, 1, register-file write ports (1..LANES)
- DATA_W, 32, result width
- ADDR_W, 5, register address width
- PC_W, 32, PC width
- CNT_W, 32, retire counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_4  in  1  MEM bundle valid
- allow_5  out  1  WB can accept a bundle this cycle
- stage_4_to_5  in  LANES*LANE_W  bundle; lane i occupies bits [i*LANE_W +: LANE_W]; lane layout MSB->LSB is {we, dest[ADDR_W], result[DATA_W], pc[PC_W]}; LANE_W = 1+ADDR_W+DATA_W+PC_W (70 at defaults)
- flush  in  1  kill the held bundle and any bundle offered this cycle
- rf_we  out  WPORTS  per-port write enable
- rf_waddr  out  WPORTS*ADDR_W  per-port address
- rf_wdata  out  WPORTS*DATA_W  per-port data
- debug_wb_pc  out  WPORTS*PC_W  PC of the lane on each port
- debug_wb_valid  out  WPORTS  lane on this port retires this cycle (independent of we)
- wb_pend_valid  out  LANES  lane i is held, has we=1 and is not yet written
- wb_pend_dest  out  LANES*ADDR_W  dest of each held lane
- perf_retired  out  CNT_W  retired-lane counter

Behaviour:
- Derived constant: NBEATS = ceil(LANES/WPORTS).
- Registers:
  - valid_5
  - beat, width clog2(NBEATS), minimum 1 bit
  - bundle register, LANES*LANE_W bits
  - perf_retired
- Reset:
  - valid_5=0, beat=0, bundle=0, perf_retired=0.
  - All rf_we, debug_wb_valid and wb_pend_valid read 0 in the cycle after reset.
  - Reset mid-bundle discards the remaining beats. Reset has priority over flush and acceptance.
- Handshake:
  - ready_go_5 = (beat == NBEATS-1).
  - allow_5 = !valid_5 || ready_go_5. It is combinational and must not depend on valid_4.
- Accept: if valid_4 && allow_5 && !flush, then at the edge the bundle is latched, valid_5<=1 and beat<=0.
  - Back-to-back bundles at full rate are possible when NBEATS=1.
- Advance:
  - If valid_5 && !ready_go_5, then beat<=beat+1.
  - Else if valid_5 && ready_go_5 with no accept, then valid_5<=0 and beat<=0.
- Flush:
  - Takes effect at the edge: valid_5<=0, beat<=0, and the offered bundle is dropped.
  - The beat presented during the flush cycle still writes (it is already committed).
- Port mapping: port p in beat b carries lane L = b*WPORTS+p.
  - If L >= LANES (tail of the last beat), the port is idle: rf_we=0 and debug_wb_valid=0.
- Per-port outputs:
  - rf_we[p] = valid_5 & lane_we & (dest != 0) & !shadowed.
  - debug_wb_valid[p] = valid_5 & lane exists.
  - rf_waddr, rf_wdata and debug_wb_pc are driven from the lane, including when the port is idle.
  - shadowed: a higher port in the same beat has we=1 and the same nonzero dest. Program order is ascending lane index, so the youngest write wins.
- Pending outputs:
  - wb_pend_valid[i] = valid_5 & we_i & dest_i != 0 & (i >= beat*WPORTS).
  - Lanes in the current beat count as pending because the register file updates at the edge.
- perf_retired: adds popcount(debug_wb_valid) each cycle and wraps modulo 2^CNT_W.

Decomposition:
- Shared package wb_pkg holds:
  - lane_w(ADDR_W,DATA_W,PC_W) function
  - field offset constants WE_OFF, DEST_OFF, RES_OFF, PC_OFF
  - nbeats(LANES,WPORTS) function
  - the lane struct typedef used by MEM and WB
- Sub-module wb_beat_sel:
  - Combinational; selects WPORTS lanes for a given beat.
  - Applies existence, dest-0 and shadow masking.
  - Instantiated once.

Test Plan:
1. Defaults (LANES=2, WPORTS=1): reset, then one bundle with lane0 {we=1, dest=3, result=0x11, pc=0x1c000000} and lane1 {we=1, dest=4, result=0x22, pc=0x1c000004}.
   - Cycle 1: rf_we=1, waddr=3, allow_5=0.
   - Cycle 2: waddr=4, allow_5=1.
   - perf_retired ends at 2.
2. LANES=2, WPORTS=2, both lanes dest=5 with results 0xA and 0xB.
   - One beat; rf_we=2'b10, so only port1 writes 0xB.
   - debug_wb_valid=2'b11.
   - allow_5 stays 1 with valid_4 held high, giving one bundle per cycle.
3. Lane with dest=0 and we=1, followed by a lane with we=0.
   - rf_we=0 on both beats.
   - debug_wb_valid pulses once per beat, and perf_retired increments by 2.
4. Flush asserted in beat 0 of a 2-beat bundle.
   - Lane0 is still written; lane1 is never written.
   - valid_5=0 next cycle, and a bundle offered during the flush cycle is not latched.
5. Reset asserted in beat 0 mid-bundle.
   - Next cycle: all rf_we=0, wb_pend_valid=0, perf_retired=0, allow_5=1.
6. LANES=3, WPORTS=2.
   - Beat 1 drives port1 idle (rf_we[1]=0, debug_wb_valid[1]=0).
   - wb_pend_valid goes 3'b111 -> 3'b100 -> 3'b000.
